// File: rtl/mux_arbiter.sv
// Grant arbiter for a registered 3:1 mux with per-owner burst limiting.
// Define MUX_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module mux_arbiter #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic       sel1,
  output logic       sel2,
  output logic       sel3,
  output logic       busy,
  output logic       out_valid,
  output logic [1:0] out_src
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [3:0] BL = 4'(BURST_LEN);

  state_t     state;
  state_t     state_nx;
  logic [2:0] gnt_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic [2:0] cand;
  logic [2:0] win;
  logic       hold;
  logic       sat;
  logic       new_gnt;

  function automatic logic [2:0] fix_pick(
    input logic [2:0] m
  );
    logic [2:0] f;
    f = 3'b000;
    priority case (1'b1)
      m[0]:    f = 3'b001;
      m[1]:    f = 3'b010;
      m[2]:    f = 3'b100;
      default: f = 3'b000;
    endcase
    return f;
  endfunction

  function automatic logic [1:0] enc(
    input logic [2:0] g
  );
    logic [1:0] e;
    e = 2'd0;
    priority case (1'b1)
      g[1]:    e = 2'd1;
      g[2]:    e = 2'd2;
      default: e = 2'd0;
    endcase
    return e;
  endfunction

`ifdef MUX_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr;

  // Rotate so the search starts after ptr, pick, rotate back.
  function automatic logic [2:0] rr_pick(
    input logic [2:0] m,
    input logic [1:0] p
  );
    logic [2:0] r;
    logic [2:0] f;
    logic [2:0] o;
    r = m;
    f = 3'b000;
    o = 3'b000;
    unique case (p)
      2'd0: begin
        r = {m[0], m[2], m[1]};
        f = fix_pick(r);
        o = {f[1], f[0], f[2]};
      end
      2'd1: begin
        r = {m[1], m[0], m[2]};
        f = fix_pick(r);
        o = {f[0], f[2], f[1]};
      end
      default: begin
        o = fix_pick(m);
      end
    endcase
    return o;
  endfunction

  always_comb win = rr_pick(cand, ptr);
`else
  always_comb win = fix_pick(cand);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt       <= 3'b000;
      cnt       <= 4'd0;
      out_valid <= 1'b0;
      out_src   <= 2'd0;
    end else begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      cnt       <= cnt_nx;
      out_valid <= |gnt;
      out_src   <= enc(gnt);
    end
  end

`ifdef MUX_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= 2'd2;
    end else if (new_gnt) begin
      ptr <= enc(gnt_nx);
    end
  end
`endif

  // Owner is masked out only when its burst is spent and it still asks.
  always_comb begin
    hold = |(req & gnt);
    sat  = (cnt == BL);
    cand = req;
    if (state == GRANT && hold && sat) begin
      cand = req & ~gnt;
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    cnt_nx   = cnt;
    new_gnt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nx = GRANT;
          gnt_nx   = win;
          cnt_nx   = 4'd1;
          new_gnt  = 1'b1;
        end
      end
      GRANT: begin
        if (!hold) begin
          if (|cand) begin
            gnt_nx  = win;
            cnt_nx  = 4'd1;
            new_gnt = 1'b1;
          end else begin
            state_nx = IDLE;
            gnt_nx   = 3'b000;
            cnt_nx   = 4'd0;
          end
        end else if (!sat) begin
          cnt_nx = cnt + 4'd1;
        end else if (|cand) begin
          gnt_nx  = win;
          cnt_nx  = 4'd1;
          new_gnt = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = 3'b000;
        cnt_nx   = 4'd0;
      end
    endcase
  end

  always_comb begin
    sel1 = gnt[0];
    sel2 = gnt[1];
    sel3 = gnt[2];
    busy = |gnt;
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter in the fixed-priority build.
// Three instances share stimulus: BURST_LEN 4, 2 and 1.
module tb_mux_arbiter;

  logic       clock;
  logic       reset_n;
  logic [2:0] req;

  logic [2:0] g4, g2, g1;
  logic       s14, s24, s34, b4, v4;
  logic       s12, s22, s32, b2, v2;
  logic       s11, s21, s31, b1, v1;
  logic [1:0] o4, o2, o1;

  int checks = 0;
  int errors = 0;

  mux_arbiter #(.BURST_LEN(4)) u4 (
    .clock(clock), .reset_n(reset_n), .req(req),
    .gnt(g4), .sel1(s14), .sel2(s24), .sel3(s34),
    .busy(b4), .out_valid(v4), .out_src(o4)
  );

  mux_arbiter #(.BURST_LEN(2)) u2 (
    .clock(clock), .reset_n(reset_n), .req(req),
    .gnt(g2), .sel1(s12), .sel2(s22), .sel3(s32),
    .busy(b2), .out_valid(v2), .out_src(o2)
  );

  mux_arbiter #(.BURST_LEN(1)) u1 (
    .clock(clock), .reset_n(reset_n), .req(req),
    .gnt(g1), .sel1(s11), .sel2(s21), .sel3(s31),
    .busy(b1), .out_valid(v1), .out_src(o1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_g4"}, {29'd0, g4}, 32'd0);
    chk({tag, "_sel4"}, {29'd0, s34, s24, s14}, 32'd0);
    chk({tag, "_busy4"}, {31'd0, b4}, 32'd0);
    chk({tag, "_v4"}, {31'd0, v4}, 32'd0);
    chk({tag, "_o4"}, {30'd0, o4}, 32'd0);
    chk({tag, "_g2"}, {29'd0, g2}, 32'd0);
    chk({tag, "_g1"}, {29'd0, g1}, 32'd0);
  endtask

  logic [2:0] exp4 [6];
  logic [2:0] exp2 [6];
  logic [2:0] exp1 [6];

  initial begin
    exp4 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010};
    exp2 = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b001, 3'b001};
    exp1 = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};

    req     = 3'b000;
    reset_n = 1'b0;
    #1;
    chk_clear("rst0");
    step();
    step();
    chk_clear("rst1");
    #3;
    reset_n = 1'b1;

    // single requester ip2
    req = 3'b010;
    step();
    chk("r27_gnt", {29'd0, g4}, 32'h2);
    chk("r27_sel", {29'd0, s34, s24, s14}, 32'h2);
    chk("r27_busy", {31'd0, b4}, 32'h1);
    chk("r27_v0", {31'd0, v4}, 32'h0);
    step();
    chk("r27_v1", {31'd0, v4}, 32'h1);
    chk("r27_src", {30'd0, o4}, 32'h1);
    req = 3'b000;
    step();
    chk("drop_gnt", {29'd0, g4}, 32'h0);
    chk("drop_v", {31'd0, v4}, 32'h1);
    chk("drop_src", {30'd0, o4}, 32'h1);
    step();
    chk("drop_v2", {31'd0, v4}, 32'h0);
    chk("drop_busy", {31'd0, b4}, 32'h0);

    // full contention under three burst lengths
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("bl4_%0d", i), {29'd0, g4}, {29'd0, exp4[i]});
      chk($sformatf("bl2_%0d", i), {29'd0, g2}, {29'd0, exp2[i]});
      chk($sformatf("bl1_%0d", i), {29'd0, g1}, {29'd0, exp1[i]});
    end
    req = 3'b000;
    step();
    chk("idle_a4", {29'd0, g4}, 32'h0);
    chk("idle_a1", {29'd0, g1}, 32'h0);

    // owner drops with ip3 pending: no bubble
    req = 3'b001;
    step();
    chk("r30_a", {29'd0, g4}, 32'h1);
    req = 3'b101;
    step();
    chk("r30_b", {29'd0, g4}, 32'h1);
    req = 3'b100;
    step();
    chk("r30_sw", {29'd0, g4}, 32'h4);
    chk("r30_busy", {31'd0, b4}, 32'h1);
    chk("r30_sel3", {31'd0, s34}, 32'h1);
    step();
    chk("r30_v", {31'd0, v4}, 32'h1);
    chk("r30_src", {30'd0, o4}, 32'h2);
    req = 3'b000;
    step();
    chk("idle_b4", {29'd0, g4}, 32'h0);

    // lone requester saturates, then yields at once
    req = 3'b001;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("sat4_%0d", i), {29'd0, g4}, 32'h1);
      chk($sformatf("sat1_%0d", i), {29'd0, g1}, 32'h1);
    end
    req = 3'b011;
    step();
    chk("sat_sw4", {29'd0, g4}, 32'h2);
    chk("sat_sw2", {29'd0, g2}, 32'h2);
    chk("sat_sw1", {29'd0, g1}, 32'h2);

    // asynchronous reset mid-grant
    #3;
    reset_n = 1'b0;
    #1;
    chk_clear("arst");
    #2;
    reset_n = 1'b1;
    req = 3'b111;
    step();
    chk("post_g4", {29'd0, g4}, 32'h1);
    chk("post_g2", {29'd0, g2}, 32'h1);
    chk("post_v4", {31'd0, v4}, 32'h0);
    req = 3'b000;
    step();
    chk("post_v4b", {31'd0, v4}, 32'h1);
    chk("post_src", {30'd0, o4}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
